// File: rtl/dice_turn_controller_if.sv
// Move handshake between the turn controller and the board logic.
// The controller drives the move command; the board answers with move_ready.
interface dice_turn_controller_if;
  logic       move_valid;
  logic       move_ready;
  logic [1:0] move_player;
  logic [2:0] move_steps;

  modport master (
    output move_valid,
    output move_player,
    output move_steps,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_player,
    input  move_steps,
    output move_ready
  );
endinterface

// File: rtl/dice_turn_controller.sv
// Turn sequencing for a dice game: wait for an empty tray, accept one coloured
// roll or skip the player on timeout, then hand the move to the board logic.
module dice_turn_controller #(
  parameter int          NUM_PLAYERS    = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd5_000_000,
  parameter logic [2:0]  RED_STEPS      = 3'd1,
  parameter logic [2:0]  GREEN_STEPS    = 3'd2,
  parameter logic [2:0]  BLUE_STEPS     = 3'd3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   game_enable,
  input  logic [1:0]             stable_color,
  input  logic                   result_ready,
  input  logic                   current_state_white,
  dice_turn_controller_if.master mv,
  output logic [1:0]             cur_player,
  output logic                   waiting_white,
  output logic                   roll_timeout,
  output logic [7:0]             roll_count
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_WHITE = 2'd1,
    S_WAIT_ROLL  = 2'd2,
    S_ISSUE      = 2'd3
  } state_t;

  localparam logic [1:0]  LAST_PLAYER = 2'(NUM_PLAYERS - 1);
  localparam logic [23:0] TMO_LAST    = TIMEOUT_CYCLES - 24'd1;

  state_t      state_q, state_d;
  logic        move_valid_q, move_valid_d;
  logic [1:0]  move_player_q, move_player_d;
  logic [2:0]  move_steps_q, move_steps_d;
  logic [1:0]  cur_player_q, cur_player_d;
  logic        waiting_white_q, waiting_white_d;
  logic        roll_timeout_q, roll_timeout_d;
  logic [7:0]  roll_count_q, roll_count_d;
  logic [23:0] tmo_cnt_q, tmo_cnt_d;

  function automatic logic [2:0] color_steps(input logic [1:0] color);
    logic [2:0] steps;
    case (color)
      2'b01:   steps = RED_STEPS;
      2'b10:   steps = GREEN_STEPS;
      2'b11:   steps = BLUE_STEPS;
      default: steps = 3'd0;
    endcase
    return steps;
  endfunction

  function automatic logic [1:0] next_player(input logic [1:0] p);
    logic [1:0] n;
    if (p == LAST_PLAYER) begin
      n = 2'd0;
    end else begin
      n = p + 2'd1;
    end
    return n;
  endfunction

  // Next-state and output computation; disable beats roll/timeout, roll beats timeout.
  always_comb begin
    state_d        = state_q;
    move_valid_d   = move_valid_q;
    move_player_d  = move_player_q;
    move_steps_d   = move_steps_q;
    cur_player_d   = cur_player_q;
    roll_timeout_d = 1'b0;
    roll_count_d   = roll_count_q;
    tmo_cnt_d      = tmo_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (game_enable) begin
          state_d = S_WAIT_WHITE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_WHITE: begin
        if (!game_enable) begin
          state_d = S_IDLE;
        end else if (current_state_white) begin
          state_d   = S_WAIT_ROLL;
          tmo_cnt_d = 24'd0;
        end else begin
          state_d = S_WAIT_WHITE;
        end
      end
      S_WAIT_ROLL: begin
        if (!game_enable) begin
          state_d = S_IDLE;
        end else if (result_ready && (stable_color != 2'b00)) begin
          move_valid_d  = 1'b1;
          move_player_d = cur_player_q;
          move_steps_d  = color_steps(stable_color);
          if (roll_count_q != 8'd255) begin
            roll_count_d = roll_count_q + 8'd1;
          end else begin
            roll_count_d = roll_count_q;
          end
          state_d = S_ISSUE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          roll_timeout_d = 1'b1;
          cur_player_d   = next_player(cur_player_q);
          state_d        = S_WAIT_WHITE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 24'd1;
        end
      end
      S_ISSUE: begin
        // A pending move is never withdrawn; disable only takes effect after transfer.
        if (move_valid_q && mv.move_ready) begin
          move_valid_d = 1'b0;
          cur_player_d = next_player(cur_player_q);
          if (game_enable) begin
            state_d = S_WAIT_WHITE;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        move_valid_d = 1'b0;
      end
    endcase

    waiting_white_d = (state_d == S_WAIT_WHITE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      move_valid_q    <= 1'b0;
      move_player_q   <= 2'd0;
      move_steps_q    <= 3'd0;
      cur_player_q    <= 2'd0;
      waiting_white_q <= 1'b0;
      roll_timeout_q  <= 1'b0;
      roll_count_q    <= 8'd0;
      tmo_cnt_q       <= 24'd0;
    end else begin
      state_q         <= state_d;
      move_valid_q    <= move_valid_d;
      move_player_q   <= move_player_d;
      move_steps_q    <= move_steps_d;
      cur_player_q    <= cur_player_d;
      waiting_white_q <= waiting_white_d;
      roll_timeout_q  <= roll_timeout_d;
      roll_count_q    <= roll_count_d;
      tmo_cnt_q       <= tmo_cnt_d;
    end
  end

  assign mv.move_valid  = move_valid_q;
  assign mv.move_player = move_player_q;
  assign mv.move_steps  = move_steps_q;
  assign cur_player     = cur_player_q;
  assign waiting_white  = waiting_white_q;
  assign roll_timeout   = roll_timeout_q;
  assign roll_count     = roll_count_q;

endmodule

// File: doc/dice_turn_controller.md
DICE_TURN_CONTROLLER -- requirements
Module: dice_turn_controller

Interface
REQ-001 SHALL have parameter NUM_PLAYERS, default 2: players in rotation, legal range 2..4.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 24'd5_000_000: roll-wait limit in clk cycles, must be >= 1.
REQ-003 SHALL have parameters RED_STEPS / GREEN_STEPS / BLUE_STEPS, defaults 3'd1 / 3'd2 / 3'd3: board steps per detected dice colour.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port game_enable, input, 1: level; 1 = game running.
REQ-007 SHALL have port stable_color, input, 2: 00=NONE, 01=RED, 10=GREEN, 11=BLUE; from colour result manager.
REQ-008 SHALL have port result_ready, input, 1: one-cycle pulse; stable_color valid in the same cycle.
REQ-009 SHALL have port current_state_white, input, 1: level; white background (empty tray) detected.
REQ-010 SHALL have port move_ready, input, 1: board logic accepts the move.
REQ-011 SHALL have port move_valid, output, 1: move command pending.
REQ-012 SHALL have port move_player, output, 2: player for the pending move.
REQ-013 SHALL have port move_steps, output, 3: steps for the pending move.
REQ-014 SHALL have port cur_player, output, 2: player whose turn it is.
REQ-015 SHALL have port waiting_white, output, 1: high while in WAIT_WHITE.
REQ-016 SHALL have port roll_timeout, output, 1: one-cycle pulse when a turn is skipped on timeout.
REQ-017 SHALL have port roll_count, output, 8: accepted rolls, saturating at 255.

Function
REQ-018 SHALL implement the FSM states IDLE, WAIT_WHITE, WAIT_ROLL, ISSUE; encoding is free.
REQ-019 IDLE: SHALL go to WAIT_WHITE when game_enable=1.
REQ-020 WAIT_WHITE: SHALL go to WAIT_ROLL in the cycle after current_state_white=1 is sampled; result_ready here is ignored.
REQ-021 WAIT_ROLL, accepted roll: on result_ready=1 with stable_color!=00, SHALL latch move_player=cur_player and move_steps=mapped steps.
REQ-022 WAIT_ROLL, accepted roll (cont.): SHALL assert move_valid on the next cycle (1-cycle latency), increment roll_count, and enter ISSUE.
REQ-023 WAIT_ROLL, NONE colour: result_ready with stable_color=00 SHALL be ignored.
REQ-024 Timeout counter: SHALL clear on entry to WAIT_ROLL and increment each cycle in WAIT_ROLL.
REQ-025 Timeout expiry: on the cycle the count reaches TIMEOUT_CYCLES-1 with no accepted roll, SHALL pulse roll_timeout for 1 cycle, advance cur_player, and enter WAIT_WHITE.
REQ-026 Timeout collision: an accepted roll in the same cycle as timeout expiry SHALL win; no roll_timeout pulse.
REQ-027 ISSUE: move_valid, move_player and move_steps SHALL hold stable until move_valid&&move_ready.
REQ-028 ISSUE transfer: on that edge move_valid SHALL clear, cur_player SHALL advance, and the FSM SHALL enter WAIT_WHITE.
REQ-029 ISSUE, move_ready pre-asserted: a transfer SHALL occur on the first ISSUE cycle.
REQ-030 Player advance: SHALL wrap NUM_PLAYERS-1 -> 0.
REQ-031 game_enable=0 in WAIT_WHITE/WAIT_ROLL: SHALL go to IDLE next cycle and win over a simultaneous result_ready or timeout; cur_player and roll_count are kept.
REQ-032 game_enable=0 in ISSUE: SHALL complete the handshake first, then go to IDLE; move_valid is never withdrawn without transfer.
REQ-033 roll_count SHALL hold at 255; further accepted rolls still issue moves.
REQ-034 waiting_white SHALL be a registered decode of state.

Reset
REQ-035 While reset=0, SHALL asynchronously force state=IDLE, move_valid=0, move_player=0, move_steps=0, cur_player=0, waiting_white=0, roll_timeout=0, roll_count=0, timeout counter=0.
REQ-036 Reset asserted mid-handshake SHALL drop move_valid immediately; release SHALL resume in IDLE on the first clk edge after reset=1.

Verification
REQ-037 Nominal: enable, white 1 cycle, result_ready with colour 10 -> move_valid=1 next cycle, move_steps=2, move_player=0; move_ready=1 -> cur_player=1, waiting_white=1.
REQ-038 Backpressure: move_ready=0 for 10 cycles -> move_valid, move_steps and move_player constant; move_ready=1 -> exactly one transfer.
REQ-039 Gating: result_ready in WAIT_WHITE, and colour 00 in WAIT_ROLL -> no move_valid, roll_count unchanged.
REQ-040 Timeout: TIMEOUT_CYCLES=8, no roll -> roll_timeout pulse exactly 8 cycles after WAIT_ROLL entry, cur_player 0->1; a roll on the expiry cycle -> move issued, no pulse.
REQ-041 Wrap/saturate: NUM_PLAYERS=3, 3 moves -> cur_player 0,1,2,0; 300 rolls -> roll_count=255.
REQ-042 Reset in ISSUE -> move_valid=0 same cycle, all outputs at reset values; game_enable=0 in ISSUE -> IDLE only after transfer.
